psum_accum: RTL and testbench

PSUM_ACCUM -- requirements
Module: psum_accum

---
 rtl/psum_accum.sv | 133 +++++++++++++
 tb/tb_psum_accum.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accum.sv
// psum_accum: saturating partial-sum accumulator with ReLU and clip.
// Takes signed (8,5) products, sums one group into a signed (ACC_W,5)
// accumulator and emits the group result as an unsigned (8,7) activation.
// ACC_W must be at least 8 so the 0..63 window check below has bits to test.

`ifndef MULT_OUT_SIZE
`define MULT_OUT_SIZE 8
`endif
`ifndef IFDATA_SIZE
`define IFDATA_SIZE 8
`endif

module psum_accum #(
    parameter int unsigned ACC_W   = 12,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [`MULT_OUT_SIZE-1:0] in_data,
    input  logic                      in_last,
    input  logic                      clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [`IFDATA_SIZE-1:0]   out_data,
    output logic                      out_sat,
    output logic                      out_ovf
);

    localparam int unsigned IN_W  = `MULT_OUT_SIZE;
    localparam int unsigned OUT_W = `IFDATA_SIZE;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned CNT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);

    typedef enum logic {
        S_ACC   = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;

    logic [SUM_W-1:0]   raw_c;
    logic [ACC_W-1:0]   sum_c;
    logic               clamp_c;
    logic               close_c;
    logic               neg_c;
    logic               big_c;
    logic [OUT_W-1:0]   conv_c;

    // Beats are only taken while accumulating and not being aborted.
    assign in_ready = (state == S_ACC) && !clr;

    // Saturating add of the sign-extended beat, plus group-close detection.
    always_comb begin
        raw_c   = {acc[ACC_W-1], acc}
                + {{(SUM_W-IN_W){in_data[IN_W-1]}}, in_data};
        clamp_c = raw_c[SUM_W-1] != raw_c[SUM_W-2];
        sum_c   = raw_c[ACC_W-1:0];
        if (clamp_c) begin
            sum_c = raw_c[SUM_W-1] ? ACC_MIN : ACC_MAX;
        end
        close_c = in_last || (cnt == CNT_LAST);
    end

    // Activation conversion: ReLU below zero, clip above 63, otherwise sum<<2.
    always_comb begin
        neg_c  = sum_c[ACC_W-1];
        big_c  = !neg_c && (|sum_c[ACC_W-2:6]);
        conv_c = OUT_W'({sum_c[5:0], 2'b00});
        if (neg_c) begin
            conv_c = '0;
        end else if (big_c) begin
            conv_c = '1;
        end
    end

    // Control FSM with accumulator, beat counter, sticky overflow and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                S_ACC: begin
                    if (clr) begin
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end else if (in_valid) begin
                        if (close_c) begin
                            out_valid <= 1'b1;
                            out_data  <= conv_c;
                            out_sat   <= big_c;
                            out_ovf   <= ovf | clamp_c;
                            acc       <= '0;
                            cnt       <= '0;
                            ovf       <= 1'b0;
                            state     <= S_DRAIN;
                        end else begin
                            acc <= sum_c;
                            cnt <= cnt + CNT_W'(1);
                            ovf <= ovf | clamp_c;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_ACC;
                    end
                end
                default: begin
                    state <= S_ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum: directed and randomized checks of psum_accum against an
// integer-arithmetic reference model of the group accumulator.

module tb_psum_accum;

    localparam int ACC_W   = 12;
    localparam int MAX_LEN = 64;
    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN = -(1 << (ACC_W - 1));

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sat;
    logic       out_ovf;

    int checks;
    int errors;

    // reference model: group sum as a plain integer
    int   m_acc;
    int   m_cnt;
    bit   m_ovf;
    bit   m_valid;
    int   m_data;
    bit   m_sat;
    bit   m_oovf;

    psum_accum #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .clr      (clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .out_ovf  (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc   = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_valid = 1'b0;
        m_data  = 0;
        m_sat   = 1'b0;
        m_oovf  = 1'b0;
    endtask

    // Apply one clock edge of the group rules to the model.
    task automatic model_edge();
        int s;
        if (!m_valid) begin
            if (clr) begin
                m_acc = 0;
                m_cnt = 0;
                m_ovf = 1'b0;
            end else if (in_valid) begin
                s = m_acc + int'($signed(in_data));
                if (s > ACC_MAX) begin
                    s = ACC_MAX;
                    m_ovf = 1'b1;
                end else if (s < ACC_MIN) begin
                    s = ACC_MIN;
                    m_ovf = 1'b1;
                end
                m_cnt++;
                if (in_last || m_cnt == MAX_LEN) begin
                    m_valid = 1'b1;
                    m_sat   = (s > 63);
                    m_data  = (s < 0) ? 0 : ((s > 63) ? 255 : s * 4);
                    m_oovf  = m_ovf;
                    m_acc   = 0;
                    m_cnt   = 0;
                    m_ovf   = 1'b0;
                end else begin
                    m_acc = s;
                end
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // One cycle: check in_ready, advance model, cross the edge, check outputs.
    task automatic tick();
        #2;
        check("in_ready", 32'(in_ready), 32'(!m_valid && !clr));
        model_edge();
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_sat", 32'(out_sat), 32'(m_sat));
            check("out_ovf", 32'(out_ovf), 32'(m_oovf));
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        idle();
    endtask

    task automatic expect_out(input string tag, input int d, input bit s, input bit o);
        check({tag, "_v"}, 32'(out_valid), 32'd1);
        check({tag, "_d"}, 32'(out_data), 32'(d));
        check({tag, "_s"}, 32'(out_sat), 32'(s));
        check({tag, "_o"}, 32'(out_ovf), 32'(o));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        idle();
        tick();
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_sat", 32'(out_sat), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        rst_n     = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_sat", 32'(out_sat), 32'd0);
        check("reset_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // 0x20 + 0x10 = 48 -> 0xC0
        beat(8'h20, 1'b0);
        beat(8'h10, 1'b1);
        expect_out("pos", 8'hC0, 1'b0, 1'b0);
        drain();

        // -0x20 + 0x10 -> ReLU
        beat(8'hE0, 1'b0);
        beat(8'h10, 1'b1);
        expect_out("relu", 8'h00, 1'b0, 1'b0);
        drain();

        // 64 clips
        beat(8'h40, 1'b1);
        expect_out("clip", 8'hFF, 1'b1, 1'b0);
        drain();

        // 63 exactly is the largest unclipped value
        beat(8'h3F, 1'b1);
        expect_out("edge63", 8'hFC, 1'b0, 1'b0);
        drain();

        // positive saturation of the accumulator
        for (int i = 0; i < 17; i++) beat(8'h7F, (i == 16));
        expect_out("ovf_pos", 8'hFF, 1'b1, 1'b1);
        drain();

        // negative saturation of the accumulator
        for (int i = 0; i < 17; i++) beat(8'h80, (i == 16));
        expect_out("ovf_neg", 8'h00, 1'b0, 1'b1);
        drain();

        // MAX_LEN closes the group without in_last
        for (int i = 0; i < MAX_LEN; i++) beat(8'h01, 1'b0);
        expect_out("maxlen", 8'hFF, 1'b1, 1'b0);
        drain();
        beat(8'h05, 1'b1);
        expect_out("after_max", 8'h14, 1'b0, 1'b0);
        drain();

        // backpressure: result held, beats refused
        out_ready = 1'b0;
        beat(8'h0A, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'b1;
            clr      = (i == 2);
            tick();
            expect_out("hold", 8'h28, 1'b0, 1'b0);
        end
        drain();
        check("bp_released", 32'(out_valid), 32'd0);
        #2;
        check("bp_ready", 32'(in_ready), 32'd1);

        // clr with a concurrent beat drops the beat and prior sum
        beat(8'h20, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h30;
        in_last  = 1'b1;
        clr      = 1'b1;
        tick();
        idle();
        check("clr_no_out", 32'(out_valid), 32'd0);
        beat(8'h08, 1'b1);
        expect_out("after_clr", 8'h20, 1'b0, 1'b0);
        drain();

        // reset in DRAIN drops the pending result
        out_ready = 1'b0;
        beat(8'h04, 1'b1);
        pulse_reset();
        out_ready = 1'b1;
        tick();
        check("no_stale", 32'(out_valid), 32'd0);

        // reset mid-group discards the partial sum
        beat(8'h30, 1'b0);
        pulse_reset();
        beat(8'h02, 1'b1);
        expect_out("mid_rst", 8'h08, 1'b0, 1'b0);
        drain();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = (r == 0) ? 8'h7F : (r == 1) ? 8'h80 : 8'($urandom);
            in_last   = ($urandom_range(0, 9) == 0);
            clr       = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) pulse_reset();
            tick();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
